// File: rtl/wave_analyzer_if.sv
// Sample stream into the wave analyzer and the measurement results coming back out.
interface wave_analyzer_if;
    logic        SAMPLE_VALID;
    logic [7:0]  SAMPLE;
    logic [2:0]  FORM;
    logic [23:0] PERIOD;
    logic [23:0] HIGH_CNT;
    logic        RESULT_VALID;
    logic        LOCKED;

    modport master (
        output SAMPLE_VALID,
        output SAMPLE,
        input  FORM,
        input  PERIOD,
        input  HIGH_CNT,
        input  RESULT_VALID,
        input  LOCKED
    );

    modport slave (
        input  SAMPLE_VALID,
        input  SAMPLE,
        output FORM,
        output PERIOD,
        output HIGH_CNT,
        output RESULT_VALID,
        output LOCKED
    );
endinterface

// File: rtl/wave_analyzer.sv
// Measures period and high time of an 8-bit DDS sample stream, classifies the waveform
// into the former's form encoding and tracks how stable that classification is.
module wave_analyzer #(
    parameter int          MID        = 128,
    parameter int          JUMP_TH    = 64,
    parameter int          LOCK_CNT   = 4,
    parameter int          MIN_PERIOD = 4,
    // Period length at which an unfinished period is abandoned as a timeout.
    parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
    input  logic           CLK,
    input  logic           RESET,
    wave_analyzer_if.slave bus
);

    localparam logic [7:0]        MID_V    = 8'(MID);
    localparam logic signed [8:0] JUMP_POS = 9'(JUMP_TH);
    localparam logic signed [8:0] JUMP_NEG = 9'(-JUMP_TH);
    localparam logic [23:0]       MIN_P    = 24'(MIN_PERIOD);
    localparam logic [7:0]        LOCK_V   = 8'(LOCK_CNT);

    localparam logic [2:0] F_SAW  = 3'b000;
    localparam logic [2:0] F_RSAW = 3'b001;
    localparam logic [2:0] F_TRI  = 3'b010;
    localparam logic [2:0] F_M50  = 3'b011;
    localparam logic [2:0] F_M25  = 3'b100;
    localparam logic [2:0] F_UNK  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEASURE
    } state_t;

    state_t state, state_nxt;

    function automatic logic [1:0] sat_inc2(input logic [1:0] cnt, input logic en);
        if (en && (cnt != 2'd3))
            return cnt + 2'd1;
        return cnt;
    endfunction

    function automatic logic [7:0] lock_next(input logic [7:0] cnt,
                                             input logic [2:0] f_new,
                                             input logic [2:0] f_old);
        if (f_new == F_UNK)
            return 8'd0;
        if (f_new != f_old)
            return 8'd1;
        if (cnt >= LOCK_V)
            return LOCK_V;
        return cnt + 8'd1;
    endfunction

    function automatic logic [2:0] classify(input logic [23:0] p,
                                            input logic [23:0] h,
                                            input logic [1:0]  u,
                                            input logic [1:0]  d,
                                            input logic        su,
                                            input logic        sd);
        logic [26:0] p1, p3, p5, h8;
        p1 = {3'b000, p};
        p3 = p1 + {2'b00, p, 1'b0};
        p5 = p1 + {1'b0, p, 2'b00};
        h8 = {h, 3'b000};
        if (p < MIN_P)
            return F_UNK;
        if ((u == 2'd0) && (d == 2'd1) && su)
            return F_SAW;
        if ((u == 2'd1) && (d == 2'd0) && sd)
            return F_RSAW;
        if ((u == 2'd0) && (d == 2'd0) && su && sd)
            return F_TRI;
        if ((u == 2'd1) && (d == 2'd1) && !su && !sd) begin
            if ((h8 >= p3) && (h8 <= p5))
                return F_M50;
            if ((h8 >= p1) && (h8 < p3))
                return F_M25;
        end
        return F_UNK;
    endfunction

    logic [7:0]        prev_p0;
    logic signed [8:0] delta;
    logic              up_jump, dn_jump, step_up, step_dn, is_high, boundary;

    logic [23:0] per_cnt, high_cnt, per_inc;
    logic [1:0]  up_cnt, dn_cnt;
    logic        su_flag, sd_flag;

    logic        clr, acc, rpt, tmo;
    logic [2:0]  form_new;
    logic [7:0]  match_cnt, match_new;

    logic [2:0]  form_p1;
    logic [23:0] period_p1, high_p1;
    logic        vld_p1, locked_p1;

    // Stage 0: per-sample features against the previously accepted sample
    assign delta    = $signed({1'b0, bus.SAMPLE}) - $signed({1'b0, prev_p0});
    assign up_jump  = (delta >= JUMP_POS);
    assign dn_jump  = (delta <= JUMP_NEG);
    assign step_up  = (delta > 9'sd0) && (delta < JUMP_POS);
    assign step_dn  = (delta < 9'sd0) && (delta > JUMP_NEG);
    assign is_high  = (bus.SAMPLE >= MID_V);
    assign boundary = (prev_p0 < MID_V) && is_high;
    assign per_inc  = per_cnt + 24'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            prev_p0 <= 8'd0;
        end else begin
            state <= state_nxt;
            if (bus.SAMPLE_VALID)
                prev_p0 <= bus.SAMPLE;
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        acc       = 1'b0;
        rpt       = 1'b0;
        tmo       = 1'b0;
        if (bus.SAMPLE_VALID) begin
            case (state)
                IDLE: state_nxt = SYNC;
                SYNC: begin
                    if (boundary) begin
                        clr       = 1'b1;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (boundary) begin
                        rpt = 1'b1;
                        clr = 1'b1;
                    end else if (per_inc == TIMEOUT) begin
                        tmo       = 1'b1;
                        state_nxt = SYNC;
                    end else begin
                        acc = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The boundary sample opens the new period, so its own contribution seeds the clear.
    always_ff @(posedge CLK) begin
        if (clr) begin
            per_cnt  <= 24'd1;
            high_cnt <= {23'd0, is_high};
            up_cnt   <= sat_inc2(2'd0, up_jump);
            dn_cnt   <= sat_inc2(2'd0, dn_jump);
            su_flag  <= step_up;
            sd_flag  <= step_dn;
        end else if (acc) begin
            per_cnt  <= per_inc;
            high_cnt <= high_cnt + {23'd0, is_high};
            up_cnt   <= sat_inc2(up_cnt, up_jump);
            dn_cnt   <= sat_inc2(dn_cnt, dn_jump);
            su_flag  <= su_flag | step_up;
            sd_flag  <= sd_flag | step_dn;
        end
    end

    assign form_new  = classify(per_cnt, high_cnt, up_cnt, dn_cnt, su_flag, sd_flag);
    assign match_new = lock_next(match_cnt, form_new, form_p1);

    // Stage 1: registered results, held until the next report
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            form_p1   <= F_UNK;
            period_p1 <= 24'd0;
            high_p1   <= 24'd0;
            vld_p1    <= 1'b0;
            locked_p1 <= 1'b0;
            match_cnt <= 8'd0;
        end else begin
            vld_p1 <= 1'b0;
            if (rpt) begin
                form_p1   <= form_new;
                period_p1 <= per_cnt;
                high_p1   <= high_cnt;
                vld_p1    <= 1'b1;
                match_cnt <= match_new;
                locked_p1 <= (match_new >= LOCK_V);
            end else if (tmo) begin
                form_p1   <= F_UNK;
                period_p1 <= 24'd0;
                high_p1   <= 24'd0;
                vld_p1    <= 1'b1;
                match_cnt <= 8'd0;
                locked_p1 <= 1'b0;
            end
        end
    end

    assign bus.FORM         = form_p1;
    assign bus.PERIOD       = period_p1;
    assign bus.HIGH_CNT     = high_p1;
    assign bus.RESULT_VALID = vld_p1;
    assign bus.LOCKED       = locked_p1;

endmodule

// File: tb/tb_wave_analyzer.sv
// Bench for wave_analyzer: directed waveforms plus random streams against a queue-based model.
module tb_wave_analyzer;

    localparam int MID        = 128;
    localparam int JUMP_TH    = 64;
    localparam int LOCK_CNT   = 4;
    localparam int MIN_PERIOD = 4;
    localparam int TMO        = 300;

    logic CLK = 1'b0;
    logic RESET;

    wave_analyzer_if bus();

    wave_analyzer #(
        .MID        (MID),
        .JUMP_TH    (JUMP_TH),
        .LOCK_CNT   (LOCK_CNT),
        .MIN_PERIOD (MIN_PERIOD),
        .TIMEOUT    (24'(TMO))
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int    n_tests = 0;
    int    n_fail  = 0;
    string scen    = "init";

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s got=%0d expected=%0d", scen, tag, got, exp);
        end
    endtask

    // Reference model: keeps the raw samples and deltas of the current period.
    int m_phase;
    int m_prev;
    int m_samp[$];
    int m_dlt[$];
    int m_form, m_period, m_high, m_match;
    bit m_locked, m_rv;

    task automatic model_reset();
        m_phase  = 0;
        m_prev   = 0;
        m_samp.delete();
        m_dlt.delete();
        m_form   = 7;
        m_period = 0;
        m_high   = 0;
        m_match  = 0;
        m_locked = 1'b0;
        m_rv     = 1'b0;
    endtask

    function automatic int ref_high();
        int h = 0;
        foreach (m_samp[i]) if (m_samp[i] >= MID) h++;
        return h;
    endfunction

    function automatic int ref_form();
        int p, h, u, d;
        bit su, sd;
        p = m_samp.size();
        h = ref_high();
        u = 0; d = 0; su = 0; sd = 0;
        foreach (m_dlt[i]) begin
            if (m_dlt[i] >= JUMP_TH)       u++;
            else if (m_dlt[i] <= -JUMP_TH) d++;
            else if (m_dlt[i] > 0)         su = 1'b1;
            else if (m_dlt[i] < 0)         sd = 1'b1;
        end
        if (u > 3) u = 3;
        if (d > 3) d = 3;
        if (p < MIN_PERIOD)                  return 7;
        if (u == 0 && d == 1 && su)          return 0;
        if (u == 1 && d == 0 && sd)          return 1;
        if (u == 0 && d == 0 && su && sd)    return 2;
        if (u == 1 && d == 1 && !su && !sd) begin
            if (3 * p <= 8 * h && 8 * h <= 5 * p) return 3;
            if (p <= 8 * h && 8 * h < 3 * p)      return 4;
        end
        return 7;
    endfunction

    task automatic model_report(input int f, input int p, input int h);
        if (f != 7 && f == m_form)
            m_match = (m_match < LOCK_CNT) ? m_match + 1 : LOCK_CNT;
        else
            m_match = (f == 7) ? 0 : 1;
        m_form   = f;
        m_period = p;
        m_high   = h;
        m_locked = (m_match >= LOCK_CNT);
        m_rv     = 1'b1;
    endtask

    task automatic model_accept(input bit v, input int s);
        int d;
        bit bnd;
        m_rv = 1'b0;
        if (v) begin
            d   = s - m_prev;
            bnd = (m_prev < MID) && (s >= MID);
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (m_phase == 1) begin
                if (bnd) begin
                    m_samp  = {s};
                    m_dlt   = {d};
                    m_phase = 2;
                end
            end else begin
                if (bnd) begin
                    model_report(ref_form(), m_samp.size(), ref_high());
                    m_samp = {s};
                    m_dlt  = {d};
                end else begin
                    m_samp.push_back(s);
                    m_dlt.push_back(d);
                    if (m_samp.size() == TMO) begin
                        m_form   = 7;
                        m_period = 0;
                        m_high   = 0;
                        m_match  = 0;
                        m_locked = 1'b0;
                        m_rv     = 1'b1;
                        m_phase  = 1;
                    end
                end
            end
            m_prev = s;
        end
    endtask

    task automatic step(input bit v, input int s);
        bus.SAMPLE_VALID = v;
        bus.SAMPLE       = 8'(s);
        @(posedge CLK);
        model_accept(v, s);
        @(negedge CLK);
        check_val("rv",     bus.RESULT_VALID, m_rv);
        check_val("form",   bus.FORM,         m_form);
        check_val("locked", bus.LOCKED,       m_locked);
        check_val("period", bus.PERIOD,       m_period);
        check_val("high",   bus.HIGH_CNT,     m_high);
    endtask

    task automatic expect_out(input int f, input int p, input int h, input bit l);
        check_val("exp_form",   bus.FORM,     f);
        check_val("exp_period", bus.PERIOD,   p);
        check_val("exp_high",   bus.HIGH_CNT, h);
        check_val("exp_locked", bus.LOCKED,   l);
    endtask

    task automatic put(input int s);
        if ($urandom_range(0, 3) == 0)
            step(1'b0, $urandom_range(0, 255));
        step(1'b1, s);
    endtask

    task automatic saw(input int periods);
        for (int k = 0; k < periods; k++)
            for (int i = 0; i < 64; i++) step(1'b1, i * 4);
    endtask

    task automatic meander(input int hi, input int lo, input int periods);
        for (int k = 0; k < periods; k++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 255);
            for (int i = 0; i < lo; i++) step(1'b1, 0);
        end
    endtask

    initial begin
        RESET            = 1'b1;
        bus.SAMPLE_VALID = 1'b0;
        bus.SAMPLE       = 8'd0;
        model_reset();
        repeat (3) @(negedge CLK);
        scen = "reset";
        expect_out(7, 0, 0, 1'b0);
        check_val("rv", bus.RESULT_VALID, 0);
        RESET = 1'b0;

        scen = "saw";
        saw(7);
        expect_out(0, 64, 32, 1'b1);

        scen = "rsaw";
        for (int k = 0; k < 7; k++)
            for (int i = 0; i < 64; i++) step(1'b1, 255 - 4 * i);
        expect_out(1, 64, 32, 1'b1);

        scen = "tri";
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 32; i++) step(1'b1, 8 * i);
            for (int i = 30; i >= 1; i--) step(1'b1, 8 * i);
        end
        expect_out(2, 62, 31, 1'b1);

        scen = "m50";
        meander(32, 32, 7);
        expect_out(3, 64, 32, 1'b1);

        scen = "m25";
        meander(16, 48, 1);
        step(1'b1, 255);
        expect_out(4, 64, 16, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 255);
        for (int i = 0; i < 48; i++) step(1'b1, 0);
        meander(16, 48, 3);
        expect_out(4, 64, 16, 1'b1);

        scen = "saw_gap";
        for (int k = 0; k < 7; k++)
            for (int i = 0; i < 64; i++) begin
                step(1'b1, i * 4);
                step(1'b0, $urandom_range(0, 255));
            end
        expect_out(0, 64, 32, 1'b1);

        scen = "short";
        for (int i = 0; i < 20; i++) step(1'b1, (i % 2 == 1) ? 255 : 0);
        expect_out(7, 2, 1, 1'b0);

        scen = "timeout";
        saw(6);
        for (int i = 0; i < TMO + 40; i++) step(1'b1, 0);
        expect_out(7, 0, 0, 1'b0);

        scen = "areset";
        saw(5);
        for (int i = 0; i < 20; i++) step(1'b1, i * 4);
        bus.SAMPLE_VALID = 1'b0;
        #2 RESET = 1'b1;
        #1;
        expect_out(7, 0, 0, 1'b0);
        check_val("rv", bus.RESULT_VALID, 0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        saw(3);
        expect_out(0, 64, 32, 1'b0);

        scen = "rnd_noise";
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 255));

        scen = "rnd_square";
        for (int k = 0; k < 40; k++) begin
            int hi, lo;
            hi = $urandom_range(1, 40);
            lo = $urandom_range(1, 40);
            for (int i = 0; i < hi; i++) put(255);
            for (int i = 0; i < lo; i++) put(0);
        end

        scen = "rnd_ramp";
        for (int k = 0; k < 12; k++) begin
            int st;
            st = 1 << $urandom_range(1, 4);
            for (int i = 0; i < 256 / st; i++) put(i * st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
